// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 UART transmitter; define UART_TX_PARITY_EN for an extra even-parity bit.
module uart_tx_unit #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_active,
    output logic       tx_serial,
    output logic       tx_done
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end   = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign tx_serial = serial_q;
    assign tx_active = active_q;
    assign tx_done   = done_q;

    // State and registered outputs; reset forces an idle line at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Next state; the line value for the next bit is chosen at the edge ending the current bit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                active_d = 1'b0;
                if (tx_start) begin
                    data_d   = tx_data;
                    state_d  = START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = DATA;
                    serial_d = data_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = ^data_q;
`else
                        state_d  = STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = data_q[idx_d];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = STOP;
                    serial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = CLEANUP;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed frames checked every cycle against a frame-position model.
module tb_uart_tx_unit;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_active, tx_serial, tx_done;
    int         total = 0;
    int         bad = 0;

    uart_tx_unit #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_active(tx_active), .tx_serial(tx_serial), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pos = cycles since the accepting edge; FRAME+1 means idle and ready
    int         pos = FRAME + 1;
    logic [7:0] mb = 8'h00;
    always @(posedge clk or posedge rst) begin
        if (rst) pos <= FRAME + 1;
        else if (pos >= FRAME + 1 && tx_start) begin
            pos <= 0;
            mb  <= tx_data;
        end else if (pos < FRAME + 1) pos <= pos + 1;
    end

    function automatic logic exp_line(input int p, input logic [7:0] b);
        int k;
        k = p / C;
        if (p >= FRAME) return 1'b1;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        chk("model_serial", {31'd0, tx_serial}, {31'd0, exp_line(pos, mb)});
        chk("model_active", {31'd0, tx_active}, {31'd0, logic'(pos < FRAME)});
        chk("model_done", {31'd0, tx_done}, {31'd0, logic'(pos == FRAME)});
    end

    // mode 0: plain, 1: tx_data changed after latch, 2: busy tx_start mid-frame
    task automatic send(input logic [7:0] d, input logic [7:0] e, input int mode, input logic par);
        logic [10:0] bits;
        int          got;
        bits = '0;
        got  = -1;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 0; k < FRAME + 2; k++) begin
            if (mode == 1 && k == 1) tx_data = 8'hFF;
            if (mode == 2 && k == 15) begin
                tx_start = 1'b1;
                tx_data  = 8'h3C;
            end
            if (mode == 2 && k == 16) tx_start = 1'b0;
            if (k % C == C / 2 && k < FRAME) bits[k/C] = tx_serial;
            if (tx_done && got < 0) got = k;
            @(negedge clk);
        end
        chk("start_bit", {31'd0, bits[0]}, 32'd0);
        chk("data_bits", {24'd0, bits[8:1]}, {24'd0, e});
        if (NB == 11) chk("parity_bit", {31'd0, bits[9]}, {31'd0, par});
        chk("stop_bit", {31'd0, bits[NB-1]}, 32'd1);
        chk("done_cycle", got, FRAME);
        chk("active_after", {31'd0, tx_active}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_serial", {31'd0, tx_serial}, 32'd1);
        chk("reset_active", {31'd0, tx_active}, 32'd0);
        chk("reset_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send(8'hA5, 8'hA5, 0, 1'b0);
        chk("a5_frame_len", FRAME, (NB == 11) ? 44 : 40);
        send(8'h55, 8'h55, 1, 1'b0);
        send(8'hA5, 8'hA5, 2, 1'b0);
        send(8'h02, 8'h02, 0, 1'b1);
        send(8'h80, 8'h80, 0, 1'b1);
        send(8'h00, 8'h00, 0, 1'b0);
`ifdef UART_TX_PARITY_EN
        send(8'h07, 8'h07, 0, 1'b1);
        send(8'h03, 8'h03, 0, 1'b0);
`endif
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_serial", {31'd0, tx_serial}, 32'd1);
        chk("midrst_active", {31'd0, tx_active}, 32'd0);
        chk("midrst_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        tx_data  = 8'h81;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("post_rst_accept", {31'd0, tx_active}, 32'd1);
        chk("post_rst_start", {31'd0, tx_serial}, 32'd0);
        repeat (FRAME + 4) @(negedge clk);
        chk("post_rst_idle", {31'd0, tx_active}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
